// File: rtl/irq_priority_encoder_8to3.sv
// Sequential 8-to-3 priority encoder. It is the encode-side partner of the
// 3:8 select decoder. Request lines are OR-ed into a pending register every
// cycle. The highest-priority pending request is presented on S with a
// valid/ready handshake. An accepted request is cleared from pending, and
// the next one is presented on the following cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   D        request lines, level-sampled every cycle
//   clr      synchronous clear of all state, takes priority over D
//   ready    consumer accepts S when valid is also high
//   S        registered index of the presented request
//   valid    registered, S holds a pending request
//   pending  current pending register
//   overflow sticky flag, a request merged into an already-pending bit
//
// Parameter:
//   LSB_HIGH 1 = bit 0 has the highest priority, 0 = bit 7 has it
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | nothing presented, valid=0, S holds old value
// PRESENT | S presented with valid=1, waiting for accept

module irq_priority_encoder_8to3 #(
    parameter int LSB_HIGH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] D,
    input  logic       clr,
    input  logic       ready,
    output logic [2:0] S,
    output logic       valid,
    output logic [7:0] pending,
    output logic       overflow
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic       accept;
    logic [7:0] ackmask;
    logic [7:0] cand;
    logic [2:0] s_nxt;
    logic       valid_nxt;
    logic [7:0] pending_nxt;
    logic       overflow_nxt;

    // Later iterations overwrite earlier ones, so the scan order decides
    // which set bit ends up winning.
    function automatic logic [2:0] enc(input logic [7:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        if (LSB_HIGH != 0) begin
            for (int i = 7; i >= 0; i--)
                if (x[i]) idx = 3'(i);
        end else begin
            for (int i = 0; i < 8; i++)
                if (x[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign accept  = valid & ready;
    assign ackmask = accept ? (8'b1 << S) : 8'h00;
    assign cand    = pending & ~ackmask;

    always_comb begin
        state_nxt    = state;
        s_nxt        = S;
        valid_nxt    = valid;
        // A D bit that arrives on the bit being accepted is OR-ed back in,
        // so that request is kept rather than lost.
        pending_nxt  = cand | D;
        overflow_nxt = overflow | (|(D & cand));

        case (state)
            IDLE: begin
                if (pending != 8'h00) begin
                    s_nxt     = enc(pending);
                    valid_nxt = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                // Without an accept everything holds. A higher-priority
                // arrival does not preempt the index already presented.
                if (accept) begin
                    if (cand != 8'h00) begin
                        s_nxt = enc(cand);
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        if (clr) begin
            state_nxt    = IDLE;
            s_nxt        = 3'd0;
            valid_nxt    = 1'b0;
            pending_nxt  = 8'h00;
            overflow_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            S        <= 3'd0;
            valid    <= 1'b0;
            pending  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            S        <= s_nxt;
            valid    <= valid_nxt;
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_irq_priority_encoder_8to3.sv
module tb_irq_priority_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] D;
    logic       clr;
    logic       ready;
    logic [2:0] S, S_m;
    logic       valid, valid_m;
    logic [7:0] pending, pending_m;
    logic       overflow, overflow_m;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_priority_encoder_8to3 #(.LSB_HIGH(1)) dut (
        .clk(clk), .rst_n(rst_n), .D(D), .clr(clr), .ready(ready),
        .S(S), .valid(valid), .pending(pending), .overflow(overflow)
    );

    irq_priority_encoder_8to3 #(.LSB_HIGH(0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .D(D), .clr(clr), .ready(ready),
        .S(S_m), .valid(valid_m), .pending(pending_m), .overflow(overflow_m)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1; D = 8'h00; ready = 1'b0;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; D = 8'h00; clr = 1'b0; ready = 1'b0;
        #12;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", valid); end
        checks++; if (S !== 3'd0) begin failures++; $display("FAIL reset_S actual=%0d expected=0", S); end
        checks++; if (pending !== 8'h00) begin failures++; $display("FAIL reset_pending actual=%h expected=00", pending); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow actual=%b expected=0", overflow); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        D = 8'h20; ready = 1'b0;
        step();
        D = 8'h00;
        checks++; if (pending !== 8'h20) begin failures++; $display("FAIL single_pending actual=%h expected=20", pending); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_valid_early actual=%b expected=0", valid); end
        step();
        checks++; if (valid !== 1'b1 || S !== 3'd5) begin failures++; $display("FAIL single_present actual=%b/%0d expected=1/5", valid, S); end
        ready = 1'b1;
        step();
        checks++; if (valid !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL single_drain actual=%b/%h expected=0/00", valid, pending); end
        ready = 1'b0;
    endtask

    task automatic test_priority();
        logic [2:0] exp_l [3];
        logic [2:0] exp_m [3];
        exp_l[0] = 3'd0; exp_l[1] = 3'd4; exp_l[2] = 3'd7;
        exp_m[0] = 3'd7; exp_m[1] = 3'd4; exp_m[2] = 3'd0;
        do_clr();
        D = 8'h91; ready = 1'b1;
        step();
        D = 8'h00;
        checks++; if (pending !== 8'h91 || pending_m !== 8'h91) begin failures++; $display("FAIL prio_pending actual=%h/%h expected=91/91", pending, pending_m); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (valid !== 1'b1 || S !== exp_l[k]) begin failures++; $display("FAIL prio_lsb_%0d actual=%b/%0d expected=1/%0d", k, valid, S, exp_l[k]); end
            checks++; if (valid_m !== 1'b1 || S_m !== exp_m[k]) begin failures++; $display("FAIL prio_msb_%0d actual=%b/%0d expected=1/%0d", k, valid_m, S_m, exp_m[k]); end
        end
        step();
        checks++; if (valid !== 1'b0 || valid_m !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL prio_drain actual=%b/%b/%h expected=0/0/00", valid, valid_m, pending); end
        ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_s [3];
        exp_s[0] = 3'd0; exp_s[1] = 3'd2; exp_s[2] = 3'd0;
        do_clr();
        D = 8'h06; ready = 1'b0;
        step();
        D = 8'h00;
        step();
        for (int k = 0; k < 5; k++) begin
            checks++; if (valid !== 1'b1 || S !== 3'd1) begin failures++; $display("FAIL bp_hold_%0d actual=%b/%0d expected=1/1", k, valid, S); end
            step();
        end
        D = 8'h01;
        step();
        D = 8'h00;
        checks++; if (valid !== 1'b1 || S !== 3'd1) begin failures++; $display("FAIL bp_no_preempt actual=%b/%0d expected=1/1", valid, S); end
        checks++; if (pending !== 8'h07) begin failures++; $display("FAIL bp_pending actual=%h expected=07", pending); end
        ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (valid !== 1'b1 || S !== exp_s[k]) begin failures++; $display("FAIL bp_seq_%0d actual=%b/%0d expected=1/%0d", k, valid, S, exp_s[k]); end
        end
        step();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL bp_drain actual=%b expected=0", valid); end
        ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_clr();
        D = 8'h08; ready = 1'b0;
        step();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_first actual=%b expected=0", overflow); end
        D = 8'h08;
        step();
        D = 8'h00;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set actual=%b expected=1", overflow); end
        step();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky actual=%b expected=1", overflow); end
        do_clr();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr actual=%b expected=0", overflow); end
        D = 8'h08;
        step();
        D = 8'h00;
        step();
        checks++; if (valid !== 1'b1 || S !== 3'd3) begin failures++; $display("FAIL rereq_present actual=%b/%0d expected=1/3", valid, S); end
        D = 8'h08; ready = 1'b1;
        step();
        D = 8'h00; ready = 1'b0;
        checks++; if (pending !== 8'h08 || overflow !== 1'b0) begin failures++; $display("FAIL rereq_kept actual=%h/%b expected=08/0", pending, overflow); end
        step();
        checks++; if (valid !== 1'b1 || S !== 3'd3) begin failures++; $display("FAIL rereq_again actual=%b/%0d expected=1/3", valid, S); end
    endtask

    task automatic test_clear_and_reset();
        do_clr();
        D = 8'h04;
        step();
        D = 8'h00;
        step();
        D = 8'hFF; clr = 1'b1;
        step();
        D = 8'h00; clr = 1'b0;
        checks++; if (pending !== 8'h00 || valid !== 1'b0 || S !== 3'd0) begin failures++; $display("FAIL clr_mid actual=%h/%b/%0d expected=00/0/0", pending, valid, S); end
        D = 8'h10;
        step();
        D = 8'h00;
        step();
        checks++; if (valid !== 1'b1 || S !== 3'd4) begin failures++; $display("FAIL rst_pre actual=%b/%0d expected=1/4", valid, S); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0 || S !== 3'd0 || pending !== 8'h00) begin failures++; $display("FAIL rst_async actual=%b/%0d/%h expected=0/0/00", valid, S, pending); end
        rst_n = 1'b1;
        step();
        checks++; if (valid !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL rst_release actual=%b/%h expected=0/00", valid, pending); end
    endtask

    task automatic test_sweep();
        logic [7:0] req;
        logic [7:0] dec;
        do_clr();
        for (int i = 0; i < 8; i++) begin
            req = 8'h01 << i;
            D = req; ready = 1'b0;
            step();
            D = 8'h00;
            step();
            dec = 8'h01 << S;
            checks++; if (valid !== 1'b1 || S !== 3'(i) || dec !== req) begin failures++; $display("FAIL sweep_%0d actual=%b/%0d/%h expected=1/%0d/%h", i, valid, S, dec, i, req); end
            ready = 1'b1;
            step();
            ready = 1'b0;
            checks++; if (valid !== 1'b0) begin failures++; $display("FAIL sweep_drain_%0d actual=%b expected=0", i, valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_overflow();
        test_clear_and_reset();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
